me_job_sequencer: RTL and testbench

- Front-end controller for the motion-estimation accelerator.
- Accepts a job request, then streams 256 current-block bytes (16x16) and 1024 search-window bytes (32x32) from a valid/ready pixel source into the accelerator's write ports.
- Pulses the accelerator start, waits for finish, and reports done or timeout to the host.
- Sits between the host/DMA stream and the accelerator top.

---
 rtl/me_job_sequencer_pkg.sv | 18 +
 rtl/me_job_sequencer_run_timer.sv | 27 ++
 rtl/me_job_sequencer.sv | 138 +++++++++++++
 tb/tb_me_job_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_job_sequencer_pkg.sv
// Shared types and sizing for the motion-estimation job sequencer.
package me_pkg;

  localparam int CURR_DEPTH   = 256;
  localparam int SEARCH_DEPTH = 1024;
  localparam int CURR_AW      = 8;
  localparam int SEARCH_AW    = 10;
  localparam int DW           = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_CURR,
    LOAD_SEARCH,
    KICK,
    RUN
  } state_t;

endpackage

// File: rtl/me_job_sequencer_run_timer.sv
// Clearable up-counter that flags when it has sat at LIMIT-1, used to bound the RUN phase.
module me_run_timer #(
  parameter int LIMIT = 65535,
  parameter int W     = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == W'(LIMIT - 1));

endmodule

// File: rtl/me_job_sequencer.sv
// Loads one current block and one search window from a pixel stream, then starts
// the accelerator and reports done or timeout.
module me_job_sequencer
  import me_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 job_valid_i,
  output logic                 job_ready_o,
  input  logic                 abort_i,
  input  logic                 pix_valid_i,
  input  logic [DW-1:0]        pix_data_i,
  output logic                 pix_ready_o,
  output logic                 curr_mem_we_o,
  output logic [CURR_AW-1:0]   curr_mem_waddr_o,
  output logic [DW-1:0]        curr_mem_wdata_o,
  output logic                 search_mem_we_o,
  output logic [SEARCH_AW-1:0] search_mem_waddr_o,
  output logic [DW-1:0]        search_mem_wdata_o,
  output logic                 acc_start_o,
  input  logic                 acc_finish_i,
  input  logic                 acc_busy_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_o
);

  state_t               state, next_state;
  logic [SEARCH_AW-1:0] addr_cnt;
  logic                 accept, write_ok, job_take, curr_last, search_last;
  logic                 run_expired, timer_clear;
  logic                 start_d, done_d, timeout_d;
  logic                 unused_busy;

  // Accelerator busy is informational only; completion is judged by finish.
  assign unused_busy = acc_busy_i;

  // Ready stays low during the done/timeout pulse so a new job starts one cycle later.
  assign job_ready_o = (state == IDLE) && !done_o && !timeout_o;
  assign pix_ready_o = (state == LOAD_CURR) || (state == LOAD_SEARCH);
  assign busy_o      = (state != IDLE);
  assign job_take    = job_valid_i & job_ready_o;
  assign accept      = pix_valid_i & pix_ready_o;
  assign write_ok    = accept & ~abort_i;
  assign curr_last   = (addr_cnt == SEARCH_AW'(CURR_DEPTH - 1));
  assign search_last = (addr_cnt == SEARCH_AW'(SEARCH_DEPTH - 1));
  assign timer_clear = (state != RUN) || abort_i;

  me_run_timer #(.LIMIT(TIMEOUT_CYCLES)) u_run_timer (
    .clk     (clk_i),
    .rst     (rst_i),
    .clear   (timer_clear),
    .enable  (state == RUN),
    .expired (run_expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    start_d    = 1'b0;
    done_d     = 1'b0;
    timeout_d  = 1'b0;
    case (state)
      IDLE:        if (job_take) next_state = LOAD_CURR;
      LOAD_CURR:   if (accept && curr_last) next_state = LOAD_SEARCH;
      LOAD_SEARCH: if (accept && search_last) next_state = KICK;
      KICK: begin
        next_state = RUN;
        start_d    = 1'b1;
      end
      RUN: begin
        if (acc_finish_i) begin
          next_state = IDLE;
          done_d     = 1'b1;
        end else if (run_expired) begin
          next_state = IDLE;
          timeout_d  = 1'b1;
        end
      end
      default:     next_state = IDLE;
    endcase
    // Abort overrides every other transition and suppresses all pulses.
    if (abort_i && (state != IDLE)) begin
      next_state = IDLE;
      start_d    = 1'b0;
      done_d     = 1'b0;
      timeout_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_cnt <= '0;
    end else if (job_take || abort_i) begin
      addr_cnt <= '0;
    end else if (write_ok) begin
      addr_cnt <= (state == LOAD_CURR && curr_last) ? '0 : addr_cnt + SEARCH_AW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      curr_mem_we_o      <= 1'b0;
      curr_mem_waddr_o   <= '0;
      curr_mem_wdata_o   <= '0;
      search_mem_we_o    <= 1'b0;
      search_mem_waddr_o <= '0;
      search_mem_wdata_o <= '0;
      acc_start_o        <= 1'b0;
      done_o             <= 1'b0;
      timeout_o          <= 1'b0;
    end else begin
      curr_mem_we_o   <= write_ok && (state == LOAD_CURR);
      search_mem_we_o <= write_ok && (state == LOAD_SEARCH);
      if (write_ok && state == LOAD_CURR) begin
        curr_mem_waddr_o <= addr_cnt[CURR_AW-1:0];
        curr_mem_wdata_o <= pix_data_i;
      end
      if (write_ok && state == LOAD_SEARCH) begin
        search_mem_waddr_o <= addr_cnt;
        search_mem_wdata_o <= pix_data_i;
      end
      acc_start_o <= start_d;
      done_o      <= done_d;
      timeout_o   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_me_job_sequencer.sv
// Self-checking bench for me_job_sequencer: scoreboarded memory writes plus
// start/done/timeout timing, abort and reset scenarios.
module tb_me_job_sequencer;
  import me_pkg::*;

  localparam int TMO = 16;

  logic                 clk;
  logic                 rst;
  logic                 job_valid, job_ready, abort, pix_valid, pix_ready;
  logic [DW-1:0]        pix_data;
  logic                 curr_we, search_we, acc_start, acc_finish, acc_busy;
  logic [CURR_AW-1:0]   curr_waddr;
  logic [SEARCH_AW-1:0] search_waddr;
  logic [DW-1:0]        curr_wdata, search_wdata;
  logic                 busy, done, timeout;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_count = 0, done_count = 0, timeout_count = 0;
  int start_cyc = -100, w1023_cyc = -100;
  logic [18:0] exp_q[$];

  me_job_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .job_valid_i        (job_valid),
    .job_ready_o        (job_ready),
    .abort_i            (abort),
    .pix_valid_i        (pix_valid),
    .pix_data_i         (pix_data),
    .pix_ready_o        (pix_ready),
    .curr_mem_we_o      (curr_we),
    .curr_mem_waddr_o   (curr_waddr),
    .curr_mem_wdata_o   (curr_wdata),
    .search_mem_we_o    (search_we),
    .search_mem_waddr_o (search_waddr),
    .search_mem_wdata_o (search_wdata),
    .acc_start_o        (acc_start),
    .acc_finish_i       (acc_finish),
    .acc_busy_i         (acc_busy),
    .busy_o             (busy),
    .done_o             (done),
    .timeout_o          (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Advance one cycle; on the falling edge pop the scoreboard against any write on the ports.
  task automatic tick();
    logic [18:0] act, exp_w;
    @(negedge clk);
    if (!rst) begin
      if (curr_we || search_we) begin
        act = search_we ? {1'b1, search_waddr, search_wdata} : {1'b0, 2'b00, curr_waddr, curr_wdata};
        checks++;
        if (curr_we && search_we) begin
          errors++;
          $display("[TB] FAIL dual_write: got curr_we=%0b search_we=%0b expected one port", curr_we, search_we);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_write: got %05h expected no write", act);
        end else begin
          exp_w = exp_q.pop_front();
          if (act !== exp_w) begin
            errors++;
            $display("[TB] FAIL write_seq: got %05h expected %05h", act, exp_w);
          end
        end
        if (search_we && search_waddr == 10'd1023) w1023_cyc = cyc;
      end
      if (acc_start) begin start_count++; start_cyc = cyc; end
      if (done) done_count++;
      if (timeout) timeout_count++;
    end
    #1;
  endtask

  task automatic request_job();
    checks++;
    if (job_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL job_idle: got ready=%0b busy=%0b expected 1/0", job_ready, busy);
    end
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    checks++;
    if (job_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL job_accept: got ready=%0b busy=%0b expected 0/1", job_ready, busy);
    end
  endtask

  // Streams bytes 0..n-1 (data = index mod 256); abort replaces byte abort_idx.
  task automatic feed(input int n, input int pct, input int abort_idx, input int stray_idx);
    int  i = 0;
    int  guard = 0;
    bit  stop = 0;
    while (i < n && !stop && guard < 20000) begin
      guard++;
      acc_finish = (stray_idx >= 0 && i == stray_idx);
      if (i == abort_idx) begin
        abort     = 1'b1;
        pix_valid = 1'b1;
        pix_data  = 8'hEE;
        stop      = 1;
      end else if ($urandom_range(99) < pct) begin
        checks++;
        if (pix_ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL pix_ready_load: got %0b expected 1 at byte %0d", pix_ready, i);
        end
        pix_valid = 1'b1;
        pix_data  = i[7:0];
        if (i < CURR_DEPTH) exp_q.push_back({1'b0, 2'b00, i[7:0], i[7:0]});
        else                exp_q.push_back({1'b1, 10'(i - CURR_DEPTH), i[7:0]});
        i++;
      end else begin
        pix_valid = 1'b0;
      end
      tick();
    end
    pix_valid  = 1'b0;
    abort      = 1'b0;
    acc_finish = 1'b0;
    checks++;
    if (!stop && i < n) begin
      errors++;
      $display("[TB] FAIL feed_budget: got %0d bytes expected %0d", i, n);
    end
  endtask

  // Full job; delay<0 means finish never comes and a timeout is expected.
  task automatic do_job(input int pct, input int delay, input int stray);
    int s0, d0, t0, rs, k;
    bit expect_done;
    s0 = start_count; d0 = done_count; t0 = timeout_count;
    expect_done = (delay >= 0);
    request_job();
    feed(CURR_DEPTH + SEARCH_DEPTH, pct, -1, stray);
    checks++;
    if (pix_ready !== 1'b0 || acc_start !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL kick: got ready=%0b start=%0b busy=%0b expected 0/0/1", pix_ready, acc_start, busy);
    end
    tick();
    checks++;
    if (acc_start !== 1'b1 || pix_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_pulse: got start=%0b ready=%0b expected 1/0", acc_start, pix_ready);
    end
    checks++;
    if (start_cyc != w1023_cyc + 1) begin
      errors++;
      $display("[TB] FAIL start_latency: got cycle %0d expected %0d", start_cyc, w1023_cyc + 1);
    end
    rs = cyc;
    acc_busy = 1'b1;
    if (expect_done) begin
      repeat (delay) tick();
      acc_finish = 1'b1;
      tick();
      acc_finish = 1'b0;
    end
    k = 0;
    while (!(done || timeout) && k < 40) begin
      tick();
      k++;
    end
    acc_busy = 1'b0;
    checks++;
    if (expect_done) begin
      if (done !== 1'b1 || timeout !== 1'b0 || cyc != rs + delay + 1) begin
        errors++;
        $display("[TB] FAIL done_pulse: got done=%0b timeout=%0b at +%0d expected 1/0 at +%0d",
                 done, timeout, cyc - rs, delay + 1);
      end
    end else begin
      if (timeout !== 1'b1 || done !== 1'b0 || cyc != rs + TMO) begin
        errors++;
        $display("[TB] FAIL timeout_pulse: got timeout=%0b done=%0b at +%0d expected 1/0 at +%0d",
                 timeout, done, cyc - rs, TMO);
      end
    end
    checks++;
    if (busy !== 1'b0 || job_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL end_cycle: got busy=%0b ready=%0b expected 0/0", busy, job_ready);
    end
    tick();
    checks++;
    if (job_ready !== 1'b1 || done !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_job: got ready=%0b done=%0b timeout=%0b busy=%0b expected 1/0/0/0",
               job_ready, done, timeout, busy);
    end
    checks++;
    if (start_count != s0 + 1 || done_count != d0 + (expect_done ? 1 : 0) ||
        timeout_count != t0 + (expect_done ? 0 : 1)) begin
      errors++;
      $display("[TB] FAIL event_counts: got start=%0d done=%0d timeout=%0d expected %0d/%0d/%0d",
               start_count - s0, done_count - d0, timeout_count - t0, 1,
               expect_done ? 1 : 0, expect_done ? 0 : 1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL writes_missing: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({job_ready, busy, pix_ready, acc_start, done, timeout, curr_we, search_we} !== 8'b1000_0000 ||
        curr_waddr !== '0 || search_waddr !== '0 || curr_wdata !== '0 || search_wdata !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: got flags=%08b expected 10000000 with zero write regs",
               {job_ready, busy, pix_ready, acc_start, done, timeout, curr_we, search_we});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_nominal();     do_job(100, 5, -1);  endtask
  task automatic test_bubbled();     do_job(50, 7, 100);  endtask
  task automatic test_timeout();     do_job(100, -1, -1); endtask
  task automatic test_coincident();  do_job(100, TMO - 1, -1); endtask

  task automatic test_stray_idle();
    int d0;
    d0 = done_count;
    repeat (3) begin
      acc_finish = 1'b1;
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || job_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stray_idle: got done=%0b busy=%0b ready=%0b expected 0/0/1", done, busy, job_ready);
      end
    end
    acc_finish = 1'b0;
    tick();
    checks++;
    if (done_count != d0) begin
      errors++;
      $display("[TB] FAIL stray_count: got %0d done pulses expected 0", done_count - d0);
    end
  endtask

  task automatic test_abort();
    int s0, d0, t0;
    s0 = start_count; d0 = done_count; t0 = timeout_count;
    request_job();
    feed(CURR_DEPTH + SEARCH_DEPTH, 100, CURR_DEPTH + 500, -1);
    checks++;
    if (job_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_idle: got ready=%0b busy=%0b expected 1/0", job_ready, busy);
    end
    repeat (10) tick();
    checks++;
    if (start_count != s0 || done_count != d0 || timeout_count != t0 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL abort_quiet: got start=%0d done=%0d timeout=%0d pending=%0d expected all 0",
               start_count - s0, done_count - d0, timeout_count - t0, exp_q.size());
    end
    do_job(100, 3, -1);
  endtask

  task automatic test_reset_mid_run();
    request_job();
    feed(CURR_DEPTH + SEARCH_DEPTH, 100, -1, -1);
    tick();
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({job_ready, busy, pix_ready, acc_start, done, timeout, curr_we, search_we} !== 8'b1000_0000) begin
      errors++;
      $display("[TB] FAIL async_reset: got flags=%08b expected 10000000",
               {job_ready, busy, pix_ready, acc_start, done, timeout, curr_we, search_we});
    end
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (job_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: got ready=%0b busy=%0b expected 1/0", job_ready, busy);
    end
    do_job(100, 2, -1);
    do_job(50, 9, -1);
  endtask

  initial begin
    rst        = 1'b1;
    job_valid  = 1'b0;
    abort      = 1'b0;
    pix_valid  = 1'b0;
    pix_data   = '0;
    acc_finish = 1'b0;
    acc_busy   = 1'b0;
    test_reset();
    test_nominal();
    test_bubbled();
    test_timeout();
    test_coincident();
    test_stray_idle();
    test_abort();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion expected finish within 1000000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
